smac_sequencer: RTL
===================

Name: smac_sequencer

Overview:
- Control FSM that sequences one S_MAC block through a full serial multiply-accumulate job and then the quantize/ReLU output phase.
- A job covers NCH = MNO/M input chunks × 4 filters × Pw weight bit-planes × Pa activation bit-planes.
- The block drives every S_MAC control input, plus bit-plane/chunk/filter indices to the data path.
- It sits between the layer controller (start/done handshake) and the S_MAC block, with an out_valid/out_ready handshake to the output buffer.

Parameters:
- M, 16, lanes per chunk (bit-adder width).
- Pa, 8, activation bits.
- Pw, 8, weight bits.
- MNO, 288, MACs per output; NCH = MNO/M, must be an integer (default 18).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  job request, sampled in IDLE only
- out_ready  in  1  output buffer accepts out_smac
- busy  out  1  high from the first cycle after start is accepted until the done cycle
- done  out  1  one-cycle pulse at job end
- out_valid  out  1  out_smac valid for filter sel_mux_relu
- ch_idx  out  clog2(NCH)  chunk index to data path
- f_idx  out  2  filter index
- w_bit_idx  out  clog2(Pw)  weight bit-plane the data path presents on wei
- a_bit_idx  out  clog2(Pa)  activation bit-plane the data path presents on act (same cycle)
- cl_en_gen, w_en_w, w_en_br, MSB_a  out  1  batch-0 controls
- w_and_s_ac1, cl_en_ac1, MSB_w, w_en_neg  out  1  batch-1 controls
- valid_ac2, cl_en_ac2  out  1; sel_ac2  out  2  batch-2 controls
- valid_ac3, cl_en_ac3, s_en_ac3  out  1; sel_ac3  out  2  batch-3 controls
- sel_mux_relu  out  2  output mux select

Interface (already decided): one clock; reset is synchronous and active-high.

Behaviour:
- Reset: on any rising edge with rst=1, all outputs go to 0, the FSM returns to IDLE, and the delay lines are flushed. This applies mid-job as well; no partial pulses follow.
- States: IDLE, LOAD_W, RUN, DRAIN, OUT, DONE.
- IDLE:
  - start=1 → LOAD_W with ch=0, f=0, wb=Pw-1.
  - start is ignored in every other state.
- Loop order: ch outer, then f, then wb (counting Pw-1 down to 0), then ab (counting Pa-1 down to 0). All bit-planes are processed MSB-first.
- LOAD_W (1 cycle): w_en_w=1, w_bit_idx=wb → RUN with ab=Pa-1.
- RUN (Pa cycles):
  - w_en_br=1, a_bit_idx=ab.
  - MSB_a=1 only when ab=Pa-1.
  - On ab=0: advance wb/f/ch and go to LOAD_W, or go to DRAIN after the last (ch,f,wb).
  - Each weight bit-plane takes Pa+1 cycles.
- Control pipeline: a shift register of tags, relative to a RUN cycle t, with t_last the ab=0 cycle of a plane.
  - t+1: cl_en_ac1=1; w_and_s_ac1=0 for the ab=Pa-1 bit (load), 1 otherwise (shift-accumulate).
  - t_last+2: w_en_neg=1; MSB_w=1 iff that plane's wb=Pw-1.
  - t_last+3: valid_ac2=1, sel_ac2=f.
  - For the wb=0 plane only, t_last+4: valid_ac3=1, sel_ac3=f, s_en_ac3=1 iff ch=0 (store rather than add).
- Pipelined overlap: the next plane's LOAD_W at t_last+1 and RUN from t_last+2 proceed in parallel with these tags. The neg latch reads AC1 before AC1 reloads at t_last+3. No stall is ever inserted.
- AC2 entry rule: ac2 receives exactly Pw consecutive valid_ac2 per entry per chunk.
- Clock enables: cl_en_gen, cl_en_ac2 and cl_en_ac3 equal busy.
- DRAIN: wait until the tag pipeline is empty, i.e. the cycle after the final valid_ac3 → OUT with sel=0.
- OUT:
  - out_valid=1, sel_mux_relu=sel.
  - If out_ready=1: sel+1; after sel=3 → DONE.
  - If out_ready=0: hold sel and out_valid indefinitely.
- DONE (1 cycle): done=1, busy=0 → IDLE. start=1 is accepted in the following IDLE cycle.
- Index outputs hold their last value when not in LOAD_W/RUN; they are 0 after reset.
- Job length: NCH·4·Pw·(Pa+1) issue cycles. With defaults this is 5184 issue cycles, plus drain and output.

Test Plan:
- Reset: assert rst for 2 cycles mid-RUN → next cycle all outputs 0, state IDLE, no valid_ac2/valid_ac3 pulse afterwards. Then start → a normal job.
- First plane, defaults, start high in cycle 0:
  - LOAD_W in cycle 1 with w_bit_idx=7.
  - RUN cycles 2–9 with a_bit_idx 7→0; MSB_a only in cycle 2.
  - w_and_s_ac1=0 in cycle 3, 1 in cycles 4–10.
  - w_en_neg with MSB_w=1 in cycle 11; valid_ac2 with sel_ac2=0 in cycle 12.
  - Second LOAD_W in cycle 10.
- Filter 0, chunk 0 completion:
  - 8 valid_ac2 pulses, in cycles 12, 21, …, 75; MSB_w only on the first.
  - valid_ac3 in cycle 76 with sel_ac3=0, s_en_ac3=1.
  - For ch=1, f=0: s_en_ac3=0.
- Full job:
  - Last RUN ends in cycle 5184; last valid_ac3 in cycle 5188 with sel_ac3=3.
  - out_valid from cycle 5189; with out_ready=1, sel_mux_relu steps 0,1,2,3 in cycles 5189–5192.
  - done in cycle 5193.
- Backpressure: out_ready=0 for 5 cycles at sel=2 → sel_mux_relu stays 2 and out_valid stays 1; it resumes on out_ready=1 and done follows after sel=3.
- start asserted while busy → ignored, counters unaffected. start held high through DONE → a new job starts in the cycle after DONE.

Source files
------------

// File: rtl/smac_sequencer.sv
// Control sequencer for one S_MAC block: walks chunks x filters x weight/activation bit-planes
// MSB-first, emits the staged accumulator controls, then steps the quantize/ReLU output mux.
module smac_sequencer #(
    parameter  int M    = 16,
    parameter  int Pa   = 8,
    parameter  int Pw   = 8,
    parameter  int MNO  = 288,
    localparam int NCH  = MNO / M,
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int WB_W = (Pw > 1) ? $clog2(Pw) : 1,
    localparam int AB_W = (Pa > 1) ? $clog2(Pa) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            out_ready,
    output logic            busy,
    output logic            done,
    output logic            out_valid,
    output logic [CH_W-1:0] ch_idx,
    output logic [1:0]      f_idx,
    output logic [WB_W-1:0] w_bit_idx,
    output logic [AB_W-1:0] a_bit_idx,
    output logic            cl_en_gen,
    output logic            w_en_w,
    output logic            w_en_br,
    output logic            MSB_a,
    output logic            w_and_s_ac1,
    output logic            cl_en_ac1,
    output logic            MSB_w,
    output logic            w_en_neg,
    output logic            valid_ac2,
    output logic            cl_en_ac2,
    output logic [1:0]      sel_ac2,
    output logic            valid_ac3,
    output logic            cl_en_ac3,
    output logic            s_en_ac3,
    output logic [1:0]      sel_ac3,
    output logic [1:0]      sel_mux_relu
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_RUN, S_DRAIN, S_OUT, S_DONE
    } state_t;

    // One tag per RUN cycle; it rides the delay line and fires the AC1/neg/AC2/AC3 controls.
    typedef struct packed {
        logic       vld;
        logic       shift;
        logic       last;
        logic       msbw;
        logic       wb0;
        logic [1:0] f;
        logic       ch0;
    } tag_t;

    state_t          r_state, w_next;
    logic [CH_W-1:0] r_ch;
    logic [1:0]      r_f;
    logic [WB_W-1:0] r_wb;
    logic [AB_W-1:0] r_ab;
    logic [1:0]      r_sel;
    tag_t            w_tag;
    tag_t            r_tag_p1, r_tag_p2, r_tag_p3, r_tag_p4;
    logic            w_last_plane;

    assign w_last_plane = (r_ch == CH_W'(NCH - 1)) && (r_f == 2'd3) && (r_wb == '0);

    always_comb begin
        w_tag = '0;
        if (r_state == S_RUN) begin
            w_tag.vld   = 1'b1;
            w_tag.shift = (r_ab != AB_W'(Pa - 1));
            w_tag.last  = (r_ab == '0);
            w_tag.msbw  = (r_wb == WB_W'(Pw - 1));
            w_tag.wb0   = (r_wb == '0);
            w_tag.f     = r_f;
            w_tag.ch0   = (r_ch == '0);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_LOAD_W;
            S_LOAD_W: w_next = S_RUN;
            S_RUN:    if (r_ab == '0) w_next = w_last_plane ? S_DRAIN : S_LOAD_W;
            // Leave once only the final AC3 tag remains in flight.
            S_DRAIN:  if (!(r_tag_p1.vld || r_tag_p2.vld || r_tag_p3.vld)) w_next = S_OUT;
            S_OUT:    if (out_ready && (r_sel == 2'd3)) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ch     <= '0;
            r_f      <= '0;
            r_wb     <= '0;
            r_ab     <= '0;
            r_sel    <= '0;
            r_tag_p1 <= '0;
            r_tag_p2 <= '0;
            r_tag_p3 <= '0;
            r_tag_p4 <= '0;
        end else begin
            r_state  <= w_next;
            r_tag_p1 <= w_tag;
            r_tag_p2 <= r_tag_p1;
            r_tag_p3 <= r_tag_p2;
            r_tag_p4 <= r_tag_p3;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ch <= '0;
                        r_f  <= '0;
                        r_wb <= WB_W'(Pw - 1);
                    end
                end
                S_LOAD_W: r_ab <= AB_W'(Pa - 1);
                S_RUN: begin
                    if (r_ab != '0) begin
                        r_ab <= r_ab - 1'b1;
                    end else if (!w_last_plane) begin
                        if (r_wb == '0) begin
                            r_wb <= WB_W'(Pw - 1);
                            if (r_f == 2'd3) begin
                                r_f  <= '0;
                                r_ch <= r_ch + 1'b1;
                            end else begin
                                r_f <= r_f + 1'b1;
                            end
                        end else begin
                            r_wb <= r_wb - 1'b1;
                        end
                    end
                end
                S_DRAIN: r_sel <= '0;
                S_OUT:   if (out_ready && (r_sel != 2'd3)) r_sel <= r_sel + 1'b1;
                default: ;
            endcase
        end
    end

    assign busy         = (r_state == S_LOAD_W) || (r_state == S_RUN) ||
                          (r_state == S_DRAIN)  || (r_state == S_OUT);
    assign done         = (r_state == S_DONE);
    assign out_valid    = (r_state == S_OUT);
    assign sel_mux_relu = (r_state == S_OUT) ? r_sel : 2'd0;
    assign ch_idx       = r_ch;
    assign f_idx        = r_f;
    assign w_bit_idx    = r_wb;
    assign a_bit_idx    = r_ab;
    assign cl_en_gen    = busy;
    assign cl_en_ac2    = busy;
    assign cl_en_ac3    = busy;
    assign w_en_w       = (r_state == S_LOAD_W);
    assign w_en_br      = (r_state == S_RUN);
    assign MSB_a        = (r_state == S_RUN) && (r_ab == AB_W'(Pa - 1));

    // Delay-line taps: t+1 AC1, t_last+2 neg latch, t_last+3 AC2, t_last+4 AC3.
    assign cl_en_ac1    = r_tag_p1.vld;
    assign w_and_s_ac1  = r_tag_p1.vld && r_tag_p1.shift;
    assign w_en_neg     = r_tag_p2.vld && r_tag_p2.last;
    assign MSB_w        = w_en_neg && r_tag_p2.msbw;
    assign valid_ac2    = r_tag_p3.vld && r_tag_p3.last;
    assign sel_ac2      = valid_ac2 ? r_tag_p3.f : 2'd0;
    assign valid_ac3    = r_tag_p4.vld && r_tag_p4.last && r_tag_p4.wb0;
    assign sel_ac3      = valid_ac3 ? r_tag_p4.f : 2'd0;
    assign s_en_ac3     = valid_ac3 && r_tag_p4.ch0;

endmodule
